motor_status_tx: RTL

Reports DC motor state back to the host over UART, the transmit direction complementing the byte-command motor controller. Snapshots direction and PWM duty, frames them into a fixed 5-byte status packet and feeds a byte-wide UART transmitter one byte at a time through a start/busy handshake. Packets are sent on host query, on state change, or on a periodic timer.

---
 rtl/motor_pkg.sv | 35 +++
 rtl/motor_status_tx_status_trigger.sv | 79 +++++++
 rtl/motor_status_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor command/status blocks.
// Holds the packet header, PWM full-scale count, duty width,
// status-flag bit positions in byte B1 and the status transmitter
// FSM state encoding, so both directions agree on the wire format.
package motor_pkg;

    localparam logic [7:0]  MOTOR_HEADER     = 8'hA5;
    localparam int unsigned MOTOR_PWM_PERIOD = 1600;
    localparam int unsigned DUTY_W           = 11;

    // Bit positions inside status byte B1
    localparam int unsigned FLAG_FWD  = 0;
    localparam int unsigned FLAG_STOP = 1;
    localparam int unsigned FLAG_SAT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } tx_state_t;

    function automatic logic [7:0] flag_byte(input logic fwd,
                                             input logic stop,
                                             input logic sat);
        logic [7:0] b;
        b            = '0;
        b[FLAG_FWD]  = fwd;
        b[FLAG_STOP] = stop;
        b[FLAG_SAT]  = sat;
        return b;
    endfunction

endpackage

// File: rtl/motor_status_tx_status_trigger.sv
// Decides when a status packet is owed to the host.
// Sources: rising edge of query, inputs differing from the last-sent
// snapshot, and a periodic timer (disabled when REPORT_PERIOD == 0).
// All sources coalesce into a single pending flag.
// Ports:
//   clk, rst            clock, async active-high reset
//   query               host request level (rising edge triggers)
//   fwd_in, duty_in     live motor state
//   take                packet start: latch snapshot, clear pending, restart timer
//   pending             a packet is owed
//   snap_fwd, snap_duty state captured at the last packet start
module status_trigger
    import motor_pkg::*;
#(
    parameter int unsigned REPORT_PERIOD = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              query,
    input  logic              fwd_in,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              take,
    output logic              pending,
    output logic              snap_fwd,
    output logic [DUTY_W-1:0] snap_duty
);

    logic query_d;
    logic query_trig;
    logic change_trig;
    logic timer_trig;

    assign query_trig  = query & ~query_d;
    assign change_trig = (fwd_in != snap_fwd) || (duty_in != snap_duty);

    generate
        if (REPORT_PERIOD == 0) begin : g_no_timer
            assign timer_trig = 1'b0;
        end else begin : g_timer
            localparam int unsigned TW = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
            localparam logic [TW-1:0] LAST = TW'(REPORT_PERIOD - 1);

            logic [TW-1:0] timer;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    timer <= '0;
                end else if (take || (timer == LAST)) begin
                    timer <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end

            // A wrap coinciding with a packet start is already served by it
            assign timer_trig = (timer == LAST) && !take;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            query_d   <= 1'b0;
            pending   <= 1'b0;
            snap_fwd  <= 1'b1;
            snap_duty <= '0;
        end else begin
            query_d <= query;
            if (take) begin
                // Triggers in the take cycle are satisfied by the snapshot taken now
                pending   <= 1'b0;
                snap_fwd  <= fwd_in;
                snap_duty <= duty_in;
            end else if (query_trig || change_trig || timer_trig) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/motor_status_tx.sv
// Motor status reporter: frames direction and duty into a 5-byte packet
// (header, flags, duty high, duty low, xor checksum) and hands the bytes
// one at a time to a UART transmitter via a start/busy handshake.
// Ports:
//   clk, rst     clock, async active-high reset
//   fwd_in       direction, 1 = forward
//   duty_in      duty count 0..PWM_PERIOD
//   query        host status request (rising edge)
//   tx_busy      UART busy
//   tx_start     one-cycle byte strobe, tx_data valid alongside
//   tx_data      byte to send, held between strobes
//   report_busy  packet in flight
//   ack_err      sticky handshake-timeout flag
module motor_status_tx
    import motor_pkg::*;
#(
    parameter int unsigned PWM_PERIOD    = MOTOR_PWM_PERIOD,
    parameter int unsigned REPORT_PERIOD = 1_000_000,
    parameter logic [7:0]  HEADER        = MOTOR_HEADER,
    parameter int unsigned ACK_TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_in,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              query,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              report_busy,
    output logic              ack_err
);

    localparam int unsigned TMW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMW-1:0] TMO_LAST = TMW'(ACK_TIMEOUT - 1);

    tx_state_t         state, state_nxt;
    logic [2:0]        idx, idx_nxt;
    logic [4:0][7:0]   pkt, pkt_nxt;
    logic [TMW-1:0]    tmo, tmo_nxt;
    logic              tx_start_nxt;
    logic [7:0]        tx_data_nxt;
    logic              busy_nxt;
    logic              err_nxt;
    logic              take;
    logic              pending;
    logic              snap_fwd;
    logic [DUTY_W-1:0] snap_duty;
    logic [7:0]        b1;

    status_trigger #(
        .REPORT_PERIOD(REPORT_PERIOD)
    ) u_trig (
        .clk       (clk),
        .rst       (rst),
        .query     (query),
        .fwd_in    (fwd_in),
        .duty_in   (duty_in),
        .take      (take),
        .pending   (pending),
        .snap_fwd  (snap_fwd),
        .snap_duty (snap_duty)
    );

    assign b1 = flag_byte(snap_fwd, snap_duty == '0, snap_duty == DUTY_W'(PWM_PERIOD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            pkt         <= '0;
            tmo         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            report_busy <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            pkt         <= pkt_nxt;
            tmo         <= tmo_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            report_busy <= busy_nxt;
            ack_err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        pkt_nxt      = pkt;
        tmo_nxt      = tmo;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        busy_nxt     = report_busy;
        err_nxt      = ack_err;
        take         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pending) begin
                    take      = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pkt_nxt[0] = HEADER;
                pkt_nxt[1] = b1;
                pkt_nxt[2] = {5'b0, snap_duty[10:8]};
                pkt_nxt[3] = snap_duty[7:0];
                pkt_nxt[4] = HEADER ^ b1 ^ {5'b0, snap_duty[10:8]} ^ snap_duty[7:0];
                idx_nxt    = '0;
                state_nxt  = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = pkt[idx];
                    tmo_nxt      = '0;
                    state_nxt    = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_LO;
                end else if (tmo == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_nxt = tmo + TMW'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx == 3'd4) begin
                        busy_nxt  = 1'b0;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = ST_SEND;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
